// File: rtl/uart_bus_loader.sv
// UART debug/boot loader: byte commands in, word bus cycles out, replies back.
// Ports: clk/reset, rx_dv/rx_byte, tx_active/tx_dv/tx_byte, mem_*, cpu_resetn, bus_own.
module uart_bus_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 2_700_000,
  parameter bit          BOOT_HALTED    = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_dv,
  input  logic [7:0]  rx_byte,
  input  logic        tx_active,
  output logic        tx_dv,
  output logic [7:0]  tx_byte,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        cpu_resetn,
  output logic        bus_own
);

  localparam logic [7:0] C_W = 8'h57;
  localparam logic [7:0] C_R = 8'h52;
  localparam logic [7:0] C_H = 8'h48;
  localparam logic [7:0] C_G = 8'h47;
  localparam logic [7:0] C_K = 8'h4B;
  localparam logic [7:0] C_E = 8'h45;
  localparam logic [7:0] C_Q = 8'h3F;
  localparam logic [31:0] C_TMAX = TIMEOUT_CYCLES - 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARGS,
    S_BUS_WR,
    S_BUS_RD,
    S_BUS_RD_WAIT,
    S_SEND,
    S_SEND_GUARD,
    S_SEND_WAIT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic        r_is_wr;
  logic [63:0] r_args;
  logic [31:0] r_timer;
  logic [31:0] r_reply;
  logic [2:0]  r_nbytes;
  logic        r_guard;
  logic        r_cpu_resetn;
  logic [63:0] w_args_next;
  logic        w_last;
  logic        w_expire;

  // Bytes arrive LSB first, so each new byte enters at the top.
  assign w_args_next = {rx_byte, r_args[63:8]};
  assign w_last      = (r_cnt == 4'd1);
  assign w_expire    = (r_timer == C_TMAX);
  assign tx_byte     = r_reply[7:0];
  assign cpu_resetn  = r_cpu_resetn;
  assign bus_own     = ~r_cpu_resetn;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    tx_dv     = 1'b0;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    unique case (r_state)
      S_IDLE: begin
        if (rx_dv) begin
          if (rx_byte == C_W || rx_byte == C_R)
            w_next = S_ARGS;
          else
            w_next = S_SEND;
        end
      end
      S_ARGS: begin
        if (rx_dv) begin
          if (w_last) begin
            if (r_cpu_resetn) w_next = S_SEND;
            else if (r_is_wr) w_next = S_BUS_WR;
            else              w_next = S_BUS_RD;
          end
        end else if (w_expire) begin
          w_next = S_IDLE;
        end
      end
      S_BUS_WR: begin
        mem_wmask = 4'b1111;
        w_next    = S_SEND;
      end
      S_BUS_RD: begin
        mem_rstrb = 1'b1;
        w_next    = S_BUS_RD_WAIT;
      end
      S_BUS_RD_WAIT: w_next = S_SEND;
      S_SEND: begin
        if (!tx_active) begin
          tx_dv  = 1'b1;
          w_next = S_SEND_GUARD;
        end
      end
      S_SEND_GUARD: begin
        if (r_guard) w_next = S_SEND_WAIT;
      end
      S_SEND_WAIT: begin
        if (!tx_active)
          w_next = (r_nbytes == 3'd1) ? S_IDLE : S_SEND;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt        <= '0;
      r_is_wr      <= 1'b0;
      r_args       <= '0;
      r_timer      <= '0;
      r_reply      <= '0;
      r_nbytes     <= '0;
      r_guard      <= 1'b0;
      r_cpu_resetn <= ~BOOT_HALTED;
      mem_addr     <= '0;
      mem_wdata    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (rx_dv) begin
            r_timer  <= '0;
            r_args   <= '0;
            r_nbytes <= 3'd1;
            case (rx_byte)
              C_W: begin
                r_cnt   <= 4'd8;
                r_is_wr <= 1'b1;
              end
              C_R: begin
                r_cnt   <= 4'd4;
                r_is_wr <= 1'b0;
              end
              C_H: begin
                r_cpu_resetn <= 1'b0;
                r_reply      <= {24'd0, C_K};
              end
              C_G: begin
                r_cpu_resetn <= 1'b1;
                r_reply      <= {24'd0, C_K};
              end
              default: r_reply <= {24'd0, C_Q};
            endcase
          end
        end
        S_ARGS: begin
          if (rx_dv) begin
            r_args  <= w_args_next;
            r_cnt   <= r_cnt - 4'd1;
            r_timer <= '0;
            if (w_last) begin
              r_reply  <= {24'd0, C_E};
              r_nbytes <= 3'd1;
              // Write args fill all 64 bits; read args sit in the top half.
              if (!r_cpu_resetn) begin
                if (r_is_wr) begin
                  mem_addr  <= w_args_next[31:0] & ~32'h3;
                  mem_wdata <= w_args_next[63:32];
                end else begin
                  mem_addr  <= w_args_next[63:32] & ~32'h3;
                end
              end
            end
          end else if (!w_expire) begin
            r_timer <= r_timer + 32'd1;
          end
        end
        S_BUS_WR: begin
          r_reply  <= {24'd0, C_K};
          r_nbytes <= 3'd1;
        end
        S_BUS_RD: ;
        S_BUS_RD_WAIT: begin
          r_reply  <= mem_rdata;
          r_nbytes <= 3'd4;
        end
        S_SEND: r_guard <= 1'b0;
        S_SEND_GUARD: r_guard <= 1'b1;
        S_SEND_WAIT: begin
          if (!tx_active && r_nbytes != 3'd1) begin
            r_reply  <= {8'd0, r_reply[31:8]};
            r_nbytes <= r_nbytes - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
